xbar_out_alloc: RTL

Output allocator for the router crossbar. Each of N_IN requesters (input ports feeding a 1-to-6 crossbar demux) asks for one of six crossbar outputs via a candidate mask. The block grants outputs with rotating priority, holds an output for a requester until the end of a multi-flit packet, and drives the registered 3-bit select for each requester's demux.

---
 rtl/xbar_out_alloc.sv | 133 +++++++++++++
 1 files changed

// File: rtl/xbar_out_alloc.sv
// Crossbar output allocator: rotating-priority grant of six outputs to N_IN requesters,
// with per-requester output locks held across multi-flit packets.
module xbar_out_alloc #(
  parameter int N_IN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   req_valid,
  input  logic [6*N_IN-1:0] req_mask,
  input  logic [N_IN-1:0]   req_last,
  output logic [N_IN-1:0]   gnt,
  output logic [3*N_IN-1:0] sel,
  output logic [5:0]        out_busy
);
  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0][5:0] mask;
  logic [N_IN-1:0]      lock_vld, win;
  logic [N_IN-1:0][2:0] lock_out, win_out, sel_q;
  logic [PW-1:0]        ptr, ptr_nxt;
  logic [5:0]           busy_nxt;

  assign mask = req_mask;
  assign sel  = sel_q;

  function automatic logic [5:0] dec6(input logic [2:0] c);
    dec6 = '0;
    for (int k = 0; k < 6; k++)
      if (c == 3'(k)) dec6[k] = 1'b1;
  endfunction

  always_comb begin
    logic [5:0] taken;
    logic [5:0] avail;
    logic       found;
    int         i;
    taken    = '0;
    avail    = '0;
    found    = 1'b0;
    i        = 0;
    win      = '0;
    win_out  = '0;
    ptr_nxt  = ptr;
    busy_nxt = '0;

    // Locked outputs stay reserved even when their owner pauses mid-packet.
    for (int r = 0; r < N_IN; r++) begin
      if (lock_vld[r]) begin
        taken = taken | dec6(lock_out[r]);
        if (req_valid[r]) begin
          win[r]     = 1'b1;
          win_out[r] = lock_out[r];
        end
      end
    end

    // Walk requesters ptr, ptr+1, ... over a doubled index range to avoid a modulo.
    for (int p = 0; p < 2*N_IN; p++) begin
      if (p >= int'(ptr) && p < int'(ptr) + N_IN) begin
        i = (p >= N_IN) ? p - N_IN : p;
        if (!lock_vld[i] && req_valid[i]) begin
          avail = mask[i] & ~taken;
          if (avail != 6'd0) begin
            for (int k = 5; k >= 0; k--)
              if (avail[k]) win_out[i] = 3'(k);
            win[i] = 1'b1;
            taken  = taken | dec6(win_out[i]);
            if (!found) begin
              found   = 1'b1;
              ptr_nxt = (i == N_IN-1) ? '0 : PW'(i + 1);
            end
          end
        end
      end
    end

    for (int r = 0; r < N_IN; r++)
      if (win[r]) busy_nxt = busy_nxt | dec6(win_out[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      out_busy <= '0;
    end else begin
      ptr      <= ptr_nxt;
      out_busy <= busy_nxt;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_lane
    xbar_alloc_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .win      (win[g]),
      .win_out  (win_out[g]),
      .last     (req_last[g]),
      .gnt      (gnt[g]),
      .sel      (sel_q[g]),
      .lock_vld (lock_vld[g]),
      .lock_out (lock_out[g])
    );
  end
endmodule

// Per-requester registered grant/select and packet lock state.
module xbar_alloc_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       win,
  input  logic [2:0] win_out,
  input  logic       last,
  output logic       gnt,
  output logic [2:0] sel,
  output logic       lock_vld,
  output logic [2:0] lock_out
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 1'b0;
      sel      <= 3'd7;
      lock_vld <= 1'b0;
      lock_out <= 3'd0;
    end else begin
      gnt <= win;
      sel <= win ? win_out : 3'd7;
      if (win) begin
        lock_vld <= ~last;
        lock_out <= win_out;
      end
    end
  end
endmodule
